// File: rtl/hcp_addsub_pipe_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
package hcp_addsub_pipe_pkg;

   localparam int unsigned ADDSUB_WIDTH = 16;

   localparam logic ADDSUB_OP_ADD = 1'b0;
   localparam logic ADDSUB_OP_SUB = 1'b1;

   typedef struct packed {
      logic cout;
      logic ovf;
   } addsub_flags_t;

endpackage

// File: rtl/hcp_addsub_pipe_if.sv
// Operand/result handshake bundle for hcp_addsub_pipe.
interface hcp_addsub_pipe_if
   import hcp_addsub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = ADDSUB_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

endinterface

// File: rtl/hcp_pair_cell.sv
// One 2-bit adder block: bit 0 adds with cin (half add when cin is tied low), bit 1 ripples from bit 0.
module hcp_pair_cell (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] s,
   output logic       cout
);

   logic c0;

   always_comb begin
      s[0] = a[0] ^ b[0] ^ cin;
      c0   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
      s[1] = a[1] ^ b[1] ^ c0;
      cout = (a[1] & b[1]) | (c0 & (a[1] ^ b[1]));
   end

endmodule

// File: rtl/hcp_addsub_pipe.sv
// Two-stage pipelined add/subtract: stage 1 forms 2-bit block sums and carries,
// stage 2 resolves the block carry chain and derives carry-out and signed overflow.
module hcp_addsub_pipe
   import hcp_addsub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
   input logic              clk,
   input logic              rst,
   hcp_addsub_pipe_if.slave bus
);

   localparam int unsigned NB = WIDTH / 2;

   logic             s1_valid;
   logic             out_valid;
   logic             in_ready;
   logic             adv2;
   logic             in_fire;
   logic             s2_load;

   logic             cin;
   logic [WIDTH-1:0] bp;
   logic [NB-1:0]    cin_vec;
   logic [WIDTH-1:0] s1_sum_c;
   logic [NB-1:0]    bc_c;

   logic [WIDTH-1:0] s1_sum;
   logic [NB-1:0]    bc;
   logic             a_msb;
   logic             bp_msb;

   logic [WIDTH-1:0] sum_c;
   addsub_flags_t    flags_c;
   logic [WIDTH-1:0] out_sum;
   addsub_flags_t    flags;

   // Handshake: stage 2 moves when empty or drained; stage 1 accepts when it can pass on.
   assign adv2     = ~out_valid | bus.out_ready;
   assign in_ready = ~s1_valid | adv2;
   assign in_fire  = bus.in_valid & in_ready;
   assign s2_load  = s1_valid & adv2;

   assign cin     = (bus.in_sub != ADDSUB_OP_ADD);
   assign bp      = (bus.in_sub == ADDSUB_OP_SUB) ? ~bus.in_b : bus.in_b;
   assign cin_vec = {{(NB - 1){1'b0}}, cin};

   for (genvar k = 0; k < NB; k++) begin : g_cell
      hcp_pair_cell u_cell (
         .a    (bus.in_a[2*k+1:2*k]),
         .b    (bp[2*k+1:2*k]),
         .cin  (cin_vec[k]),
         .s    (s1_sum_c[2*k+1:2*k]),
         .cout (bc_c[k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         bc       <= '0;
         a_msb    <= 1'b0;
         bp_msb   <= 1'b0;
      end else begin
         s1_valid <= in_fire | (s1_valid & ~adv2);
         if (in_fire) begin
            s1_sum <= s1_sum_c;
            bc     <= bc_c;
            a_msb  <= bus.in_a[WIDTH-1];
            bp_msb <= bp[WIDTH-1];
         end
      end
   end

   // Block-to-block carry resolution; a block propagates only when both its sum bits are set.
   always_comb begin
      logic r;
      r     = 1'b0;
      sum_c = '0;
      for (int k = 0; k < int'(NB); k++) begin
         sum_c[2*k]   = s1_sum[2*k] ^ r;
         sum_c[2*k+1] = s1_sum[2*k+1] ^ (s1_sum[2*k] & r);
         r            = bc[k] | (s1_sum[2*k] & s1_sum[2*k+1] & r);
      end
      flags_c.cout = r;
      flags_c.ovf  = (a_msb == bp_msb) & (sum_c[WIDTH-1] != a_msb);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         flags     <= '0;
      end else begin
         out_valid <= s2_load | (out_valid & ~bus.out_ready);
         if (s2_load) begin
            out_sum <= sum_c;
            flags   <= flags_c;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = out_sum;
   assign bus.out_cout  = flags.cout;
   assign bus.out_ovf   = flags.ovf;

endmodule

// File: tb/tb_hcp_addsub_pipe.sv
// Self-checking bench for hcp_addsub_pipe: arithmetic model plus scoreboard and directed vectors.
module tb_hcp_addsub_pipe;
   import hcp_addsub_pipe_pkg::*;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hcp_addsub_pipe_if #(.WIDTH(W)) bus ();
   hcp_addsub_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   tests = 0;
   int   fails = 0;
   int   pops  = 0;
   res_t expq[$];
   res_t prev;
   res_t mon_e;
   logic prev_stall = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Result from integer arithmetic: signed range test for overflow, unsigned compare for carry.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      res_t r;
      int   sa, sb, sr;
      sa    = int'($signed(a));
      sb    = int'($signed(b));
      sr    = sub ? (sa - sb) : (sa + sb);
      r.ovf = (sr > 32767) || (sr < -32768);
      if (sub) begin
         r.sum  = a - b;
         r.cout = (a >= b);
      end else begin
         r.sum  = a + b;
         r.cout = (int'(a) + int'(b)) > 65535;
      end
      return r;
   endfunction

   function automatic res_t dut_res();
      return res_t'({bus.out_sum, bus.out_cout, bus.out_ovf});
   endfunction

   // Scoreboard: every accepted op is expected back in order; stalled outputs must hold.
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'(dut_res()), 32'(prev));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
               mon_e = expq.pop_front();
               pops++;
               chk("result", 32'(dut_res()), 32'(mon_e));
            end
         end
         if (bus.in_valid && bus.in_ready)
            expq.push_back(model(bus.in_a, bus.in_b, bus.in_sub));
         prev_stall = bus.out_valid & ~bus.out_ready;
         prev       = dut_res();
      end
   end

   task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input res_t want);
      int n;
      @(posedge clk); #1;
      chk({name, "_model"}, 32'(model(a, b, sub)), 32'(want));
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_sub    = sub;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk({name, "_accept"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_lat1"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk({name, "_lat2"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_res"}, 32'(dut_res()), 32'(want));
   endtask

   logic [W-1:0] sa_q[8];
   logic [W-1:0] sb_q[8];
   logic         ss_q[8];
   int           acc;
   int           idx;
   int           pops0;
   int           n;
   logic         fire;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = ADDSUB_OP_ADD;
      bus.out_ready = 1'b0;
      #22;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_res", 32'(dut_res()), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed arithmetic corners
      run_one("add_basic", 16'h1234, 16'h0FED, ADDSUB_OP_ADD, res_t'({16'h2221, 1'b0, 1'b0}));
      run_one("sub_borrow", 16'h0005, 16'h0007, ADDSUB_OP_SUB, res_t'({16'hFFFE, 1'b0, 1'b0}));
      run_one("sub_minneg", 16'h8000, 16'h0001, ADDSUB_OP_SUB, res_t'({16'h7FFF, 1'b1, 1'b1}));
      run_one("add_posovf", 16'h7FFF, 16'h0001, ADDSUB_OP_ADD, res_t'({16'h8000, 1'b0, 1'b1}));
      run_one("add_wrap", 16'hFFFF, 16'h0001, ADDSUB_OP_ADD, res_t'({16'h0000, 1'b1, 1'b0}));
      run_one("sub_equal", 16'h1234, 16'h1234, ADDSUB_OP_SUB, res_t'({16'h0000, 1'b1, 1'b0}));
      run_one("sub_0_min", 16'h0000, 16'h8000, ADDSUB_OP_SUB, res_t'({16'h8000, 1'b0, 1'b1}));

      // Streaming: 8 back-to-back ops with out_ready held high
      for (int i = 0; i < 8; i++) begin
         sa_q[i] = 16'($urandom);
         sb_q[i] = 16'($urandom);
         ss_q[i] = 1'($urandom);
      end
      @(posedge clk); #1;
      pops0         = pops;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = sa_q[0];
      bus.in_b      = sb_q[0];
      bus.in_sub    = ss_q[0];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < 8) chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
         if (c >= 2) chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
         @(posedge clk); #1;
         if (c + 1 < 8) begin
            bus.in_a   = sa_q[c+1];
            bus.in_b   = sb_q[c+1];
            bus.in_sub = ss_q[c+1];
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      chk("stream_count", 32'(pops - pops0), 32'd8);

      // Backpressure: out_ready low for 4 cycles while 3 ops are offered
      sa_q[0] = 16'h0102; sb_q[0] = 16'h0304; ss_q[0] = ADDSUB_OP_ADD;
      sa_q[1] = 16'hA000; sb_q[1] = 16'h6000; ss_q[1] = ADDSUB_OP_ADD;
      sa_q[2] = 16'h0010; sb_q[2] = 16'h0020; ss_q[2] = ADDSUB_OP_SUB;
      pops0         = pops;
      acc           = 0;
      idx           = 0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = sa_q[0];
      bus.in_b      = sb_q[0];
      bus.in_sub    = ss_q[0];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         fire = bus.in_valid & bus.in_ready;
         if (fire) acc++;
         if (c == 2 || c == 3) begin
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk("bp_head", 32'(dut_res()), 32'(res_t'({16'h0406, 1'b0, 1'b0})));
         end
         if (c == 3) chk("bp_accepted", 32'(acc), 32'd2);
         if (c == 4) chk("bp_resume", 32'(bus.in_ready), 32'd1);
         @(posedge clk); #1;
         if (c == 3) bus.out_ready = 1'b1;
         if (fire) begin
            idx++;
            if (idx < 3) begin
               bus.in_a   = sa_q[idx];
               bus.in_b   = sb_q[idx];
               bus.in_sub = ss_q[idx];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      chk("bp_count", 32'(pops - pops0), 32'd3);

      // Reset with two ops in flight
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = 16'h1111;
      bus.in_b      = 16'h2222;
      bus.in_sub    = ADDSUB_OP_ADD;
      @(posedge clk); #1;
      bus.in_a = 16'h3333;
      bus.in_b = 16'h0001;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_sum", 32'(bus.out_sum), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
      end
      run_one("post_rst_op", 16'h4000, 16'h4000, ADDSUB_OP_ADD, res_t'({16'h8000, 1'b0, 1'b1}));

      n = 0;
      while (expq.size() != 0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("drain_empty", 32'(expq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
